pb_hash_absorb: RTL and testbench

- Sequential, parametrised absorb engine for the PHOTON-Beetle hash path.
- Takes a message of programmable byte length as a stream of rate-sized blocks and XORs each block into the rate part of the state supplied by the permutation datapath.
- Pads the final partial block with 0x01 followed by zeros, presents each absorbed block through a valid/ready handshake, and reports the domain-separation constant on completion.
- Replaces the fixed 4-lane combinational XOR stage.

---
 rtl/pb_hash_pkg.sv | 20 ++
 rtl/pb_pad_lanes.sv | 33 +++
 rtl/pb_hash_absorb.sv | 161 ++++++++++++++++
 tb/tb_pb_hash_absorb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_hash_pkg.sv
// Purpose: shared types and constants for the PHOTON-Beetle hash absorb engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pb_hash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    OUT,
    DONE
  } state_e;

  // First byte after the message in a partial block; later lanes are zero.
  localparam logic [7:0] PAD_BYTE   = 8'h01;

  // Domain-separation constants reported at the end of a message.
  localparam logic [2:0] CONST_FULL = 3'd1;  // length is a whole number of blocks (incl. 0)
  localparam logic [2:0] CONST_PAD  = 3'd2;  // final block was padded

endpackage

// File: rtl/pb_pad_lanes.sv
// Purpose: combinational 10*-style padder for one rate block.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   data_i   - raw message block, lane i = bits [8i+7:8i]
//   nbytes_i - number of valid message bytes (0..RATE_BYTES)
//   padded_o - lanes < nbytes_i from data_i, lane nbytes_i = PAD_BYTE
//              (only if nbytes_i < RATE_BYTES), all higher lanes zero
module pb_pad_lanes
  import pb_hash_pkg::*;
#(
  parameter int RATE_BYTES = 4,
  parameter int NB_W       = $clog2(RATE_BYTES + 1)
) (
  input  logic [8*RATE_BYTES-1:0] data_i,
  input  logic [NB_W-1:0]         nbytes_i,
  output logic [8*RATE_BYTES-1:0] padded_o
);

  always_comb begin
    padded_o = '0;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (i < int'(nbytes_i)) begin
        padded_o[8*i +: 8] = data_i[8*i +: 8];
      end else if (i == int'(nbytes_i)) begin
        // Never matches for a full block, so full blocks carry no pad byte.
        padded_o[8*i +: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/pb_hash_absorb.sv
// Purpose: sequential absorb engine; XORs padded message blocks into the rate state.
// Latency: block accepted in cycle N is presented on io_out_* in cycle N+1.
// Backpressure: input is refused while a block waits on io_out_ready; one block per 2 cycles peak.
//
// Ports:
//   clock, reset                  - clock and asynchronous active-high reset
//   io_start, io_len_bytes        - start a message of the given byte length (IDLE only)
//   io_in_valid/ready/data        - message block stream
//   io_rate_in                    - current rate part of the permutation state
//   io_out_valid/ready/data/last  - absorbed block stream towards the permutation
//   io_done, io_const             - end-of-message pulse and domain constant
//   io_blk_cnt                    - absorbed block count, present only when
//                                   PB_HASH_ABSORB_BLKCNT_EN is defined
module pb_hash_absorb
  import pb_hash_pkg::*;
#(
  parameter int RATE_BYTES = 4,
  parameter int LEN_W      = 64,
  parameter int CNT_W      = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_start,
  input  logic [LEN_W-1:0]        io_len_bytes,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic [8*RATE_BYTES-1:0] io_in_data,
  input  logic [8*RATE_BYTES-1:0] io_rate_in,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [8*RATE_BYTES-1:0] io_out_data,
  output logic                    io_out_last,
  output logic                    io_done,
`ifdef PB_HASH_ABSORB_BLKCNT_EN
  output logic [CNT_W-1:0]        io_blk_cnt,
`endif
  output logic [2:0]              io_const
);

  localparam int NB_W = $clog2(RATE_BYTES + 1);
  localparam int DW   = 8 * RATE_BYTES;

  state_e            state_q;
  logic [LEN_W-1:0]  rem_q;
  logic              pad_q;       // final absorbed block carried padding
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DW-1:0]     out_data_q;
  logic              out_last_q;
  logic              done_q;
  logic [2:0]        const_q;
`ifdef PB_HASH_ABSORB_BLKCNT_EN
  logic [CNT_W-1:0]  blk_cnt_q;
`endif

  logic              rem_short;
  logic [NB_W-1:0]   take;
  logic [DW-1:0]     padded;
  logic [DW-1:0]     out_data_d;
  logic              out_last_d;
  logic [LEN_W-1:0]  rem_d;

  // Bytes consumed by this block: min(rem, RATE_BYTES). The subtraction
  // below can therefore never wrap.
  always_comb begin
    rem_short  = rem_q < LEN_W'(RATE_BYTES);
    take       = rem_short ? rem_q[NB_W-1:0] : NB_W'(RATE_BYTES);
    out_last_d = rem_q <= LEN_W'(RATE_BYTES);
    rem_d      = rem_q - LEN_W'(take);
    out_data_d = io_rate_in ^ padded;
  end

  pb_pad_lanes #(
    .RATE_BYTES (RATE_BYTES),
    .NB_W       (NB_W)
  ) u_pad (
    .data_i   (io_in_data),
    .nbytes_i (take),
    .padded_o (padded)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      pad_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      const_q     <= '0;
`ifdef PB_HASH_ABSORB_BLKCNT_EN
      blk_cnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io_start) begin
            rem_q   <= io_len_bytes;
            const_q <= '0;
            pad_q   <= 1'b0;
`ifdef PB_HASH_ABSORB_BLKCNT_EN
            blk_cnt_q <= '0;
`endif
            if (io_len_bytes == '0) begin
              // Empty message: no blocks, pad_q=0 yields CONST_FULL.
              state_q <= DONE;
            end else begin
              state_q    <= ACCEPT;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (io_in_valid) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            pad_q       <= rem_short;
            rem_q       <= rem_d;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (io_out_ready) begin
            out_valid_q <= 1'b0;
`ifdef PB_HASH_ABSORB_BLKCNT_EN
            blk_cnt_q   <= blk_cnt_q + 1'b1;
`endif
            if (out_last_q) begin
              state_q <= DONE;
            end else begin
              state_q    <= ACCEPT;
              in_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          const_q <= pad_q ? CONST_PAD : CONST_FULL;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_in_ready  = in_ready_q;
  assign io_out_valid = out_valid_q;
  assign io_out_data  = out_data_q;
  assign io_out_last  = out_last_q;
  assign io_done      = done_q;
  assign io_const     = const_q;
`ifdef PB_HASH_ABSORB_BLKCNT_EN
  assign io_blk_cnt   = blk_cnt_q;
`endif

endmodule

// File: tb/tb_pb_hash_absorb.sv
// Directed bench for pb_hash_absorb with RATE_BYTES=4.
module tb_pb_hash_absorb;

  logic        clock;
  logic        reset;
  logic        io_start;
  logic [63:0] io_len_bytes;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_data;
  logic [31:0] io_rate_in;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_data;
  logic        io_out_last;
  logic        io_done;
  logic [2:0]  io_const;
`ifdef PB_HASH_ABSORB_BLKCNT_EN
  logic [31:0] io_blk_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pb_hash_absorb #(
    .RATE_BYTES (4),
    .LEN_W      (64),
    .CNT_W      (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (io_start),
    .io_len_bytes (io_len_bytes),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_data   (io_in_data),
    .io_rate_in   (io_rate_in),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_data  (io_out_data),
    .io_out_last  (io_out_last),
    .io_done      (io_done),
`ifdef PB_HASH_ABSORB_BLKCNT_EN
    .io_blk_cnt   (io_blk_cnt),
`endif
    .io_const     (io_const)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_msg(input logic [63:0] len);
    io_len_bytes = len;
    io_start     = 1'b1;
    tick();
    io_start     = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] d, input logic [31:0] r);
    io_in_data  = d;
    io_rate_in  = r;
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
  endtask

  task automatic drain();
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({io_in_ready, io_out_valid, io_out_last, io_done} !== 4'b0 || io_out_data !== 32'h0 || io_const !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b vld=%b last=%b done=%b data=%h const=%0d, want all zero",
               io_in_ready, io_out_valid, io_out_last, io_done, io_out_data, io_const);
    end
`ifdef PB_HASH_ABSORB_BLKCNT_EN
    n_checks++;
    if (io_blk_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_blkcnt: got %0d want 0", io_blk_cnt);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  // len=8: two full blocks, no padding block, const=1.
  task automatic test_full_blocks();
    start_msg(64'd8);
    n_checks++;
    if (io_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL t1_ready: got %b want 1", io_in_ready);
    end
    send_block(32'h44332211, 32'h0);
    n_checks++;
    if (io_out_valid !== 1'b1 || io_out_data !== 32'h44332211 || io_out_last !== 1'b0 || io_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_blk0: vld=%b data=%h last=%b rdy=%b want 1 44332211 0 0",
               io_out_valid, io_out_data, io_out_last, io_in_ready);
    end
    drain();
    n_checks++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL t1_reaccept: vld=%b rdy=%b want 0 1", io_out_valid, io_in_ready);
    end
    send_block(32'h88776655, 32'h0);
    n_checks++;
    if (io_out_valid !== 1'b1 || io_out_data !== 32'h88776655 || io_out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_blk1: vld=%b data=%h last=%b want 1 88776655 1", io_out_valid, io_out_data, io_out_last);
    end
    drain();
    n_checks++;
    if (io_done !== 1'b0 || io_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL t1_done_early: done=%b vld=%b want 0 0", io_done, io_out_valid);
    end
    tick();
    n_checks++;
    if (io_done !== 1'b1 || io_const !== 3'd1) begin
      n_fail++; $display("FAIL t1_done: done=%b const=%0d want 1 1", io_done, io_const);
    end
    tick();
    n_checks++;
    if (io_done !== 1'b0 || io_const !== 3'd1) begin
      n_fail++; $display("FAIL t1_done_pulse: done=%b const=%0d want 0 1", io_done, io_const);
    end
  endtask

  // len=3 with rate_in: lanes AA BB CC + pad 01 -> 01CCBBAA ^ 0F0F0F0F = 0EC3B4A5.
  task automatic test_partial_pad();
    start_msg(64'd3);
    n_checks++;
    if (io_const !== 3'd0) begin
      n_fail++; $display("FAIL t2_const_clear: got %0d want 0", io_const);
    end
    send_block(32'hFFCCBBAA, 32'h0F0F0F0F);
    n_checks++;
    if (io_out_data !== 32'h0EC3B4A5 || io_out_last !== 1'b1) begin
      n_fail++; $display("FAIL t2_blk: data=%h last=%b want 0ec3b4a5 1", io_out_data, io_out_last);
    end
    drain();
    tick();
    n_checks++;
    if (io_done !== 1'b1 || io_const !== 3'd2) begin
      n_fail++; $display("FAIL t2_done: done=%b const=%0d want 1 2", io_done, io_const);
    end
    tick();
  endtask

  // len=0: straight to DONE, done two cycles after start.
  task automatic test_zero_len();
    start_msg(64'd0);
    n_checks++;
    if (io_in_ready !== 1'b0 || io_out_valid !== 1'b0 || io_done !== 1'b0 || io_const !== 3'd0) begin
      n_fail++;
      $display("FAIL t3_after_start: rdy=%b vld=%b done=%b const=%0d want 0 0 0 0",
               io_in_ready, io_out_valid, io_done, io_const);
    end
    tick();
    n_checks++;
    if (io_done !== 1'b1 || io_const !== 3'd1 || io_in_ready !== 1'b0 || io_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_done: done=%b const=%0d rdy=%b vld=%b want 1 1 0 0",
               io_done, io_const, io_in_ready, io_out_valid);
    end
    tick();
    n_checks++;
    if (io_done !== 1'b0) begin
      n_fail++; $display("FAIL t3_done_pulse: got %b want 0", io_done);
    end
  endtask

  // len=5 with a 10-cycle output stall; second block: 05 01 00 00 ^ 10203040 = 10203145.
  task automatic test_backpressure();
    start_msg(64'd5);
    send_block(32'h04030201, 32'h0);
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (io_out_valid !== 1'b1 || io_out_data !== 32'h04030201 || io_out_last !== 1'b0 || io_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL t4_stall[%0d]: vld=%b data=%h last=%b rdy=%b want 1 04030201 0 0",
                 c, io_out_valid, io_out_data, io_out_last, io_in_ready);
      end
      tick();
    end
    drain();
    send_block(32'hDDCCBB05, 32'h10203040);
    n_checks++;
    if (io_out_data !== 32'h10203145 || io_out_last !== 1'b1) begin
      n_fail++; $display("FAIL t4_blk1: data=%h last=%b want 10203145 1", io_out_data, io_out_last);
    end
    drain();
    tick();
    n_checks++;
    if (io_done !== 1'b1 || io_const !== 3'd2) begin
      n_fail++; $display("FAIL t4_done: done=%b const=%0d want 1 2", io_done, io_const);
    end
    tick();
  endtask

  // Reset in OUT of a 12-byte message, then a clean 4-byte message.
  task automatic test_mid_reset();
    logic saw_done;
    start_msg(64'd12);
    send_block(32'hA1A2A3A4, 32'h0);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({io_in_ready, io_out_valid, io_out_last, io_done} !== 4'b0 || io_out_data !== 32'h0 || io_const !== 3'd0) begin
      n_fail++;
      $display("FAIL t5_async_clear: rdy=%b vld=%b last=%b done=%b data=%h const=%0d want all zero",
               io_in_ready, io_out_valid, io_out_last, io_done, io_out_data, io_const);
    end
    tick();
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (io_done === 1'b1 || io_in_ready === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++; $display("FAIL t5_no_done: activity after reset=%b want 0", saw_done);
    end
    start_msg(64'd4);
    send_block(32'hDEADBEEF, 32'hFFFFFFFF);
    n_checks++;
    if (io_out_data !== 32'h21524110 || io_out_last !== 1'b1) begin
      n_fail++; $display("FAIL t5_blk: data=%h last=%b want 21524110 1", io_out_data, io_out_last);
    end
    drain();
    tick();
    n_checks++;
    if (io_done !== 1'b1 || io_const !== 3'd1) begin
      n_fail++; $display("FAIL t5_done: done=%b const=%0d want 1 1", io_done, io_const);
    end
    tick();
  endtask

  // len=9 with a stray io_start (len=1) during ACCEPT; third block 33 01 00 00.
  task automatic test_start_ignored();
    start_msg(64'd9);
    io_len_bytes = 64'd1;
    io_start     = 1'b1;
    send_block(32'h11111111, 32'h0);
    io_start     = 1'b0;
    n_checks++;
    if (io_out_data !== 32'h11111111 || io_out_last !== 1'b0) begin
      n_fail++; $display("FAIL t6_blk0: data=%h last=%b want 11111111 0", io_out_data, io_out_last);
    end
    drain();
    send_block(32'h22222222, 32'h0);
    n_checks++;
    if (io_out_data !== 32'h22222222 || io_out_last !== 1'b0) begin
      n_fail++; $display("FAIL t6_blk1: data=%h last=%b want 22222222 0", io_out_data, io_out_last);
    end
    drain();
    send_block(32'h33333333, 32'h0);
    n_checks++;
    if (io_out_data !== 32'h00000133 || io_out_last !== 1'b1) begin
      n_fail++; $display("FAIL t6_blk2: data=%h last=%b want 00000133 1", io_out_data, io_out_last);
    end
    drain();
    tick();
    n_checks++;
    if (io_done !== 1'b1 || io_const !== 3'd2) begin
      n_fail++; $display("FAIL t6_done: done=%b const=%0d want 1 2", io_done, io_const);
    end
`ifdef PB_HASH_ABSORB_BLKCNT_EN
    n_checks++;
    if (io_blk_cnt !== 32'd3) begin
      n_fail++; $display("FAIL t6_blkcnt: got %0d want 3", io_blk_cnt);
    end
`endif
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    io_start     = 1'b0;
    io_len_bytes = '0;
    io_in_valid  = 1'b0;
    io_in_data   = '0;
    io_rate_in   = '0;
    io_out_ready = 1'b0;
    test_reset();
    test_full_blocks();
    test_partial_pad();
    test_zero_len();
    test_backpressure();
    test_mid_reset();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
